imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the 64-word x 10-bit instruction memory that the 6-bit CPU fetches from.
- Receives a framed byte stream over a valid/ready interface and assembles 10-bit instruction words ({4-bit opcode, 6-bit operand}).
- Writes the words sequentially from address 0 into the instruction RAM.
- Holds the CPU stalled while loading and flags framing or checksum errors.

Parameters:
- HDR_BYTE, 8'hA5, frame start marker
- DEPTH, 64, instruction memory words; maximum legal count

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- DIN  input  8  stream byte
- DIN_VALID  input  1  DIN is valid this cycle
- DIN_READY  output  1  loader accepts DIN this cycle (transfer = VALID & READY)
- WE  output  1  instruction RAM write enable, one-cycle pulse per word
- WA  output  6  instruction RAM write address
- WD  output  10  instruction RAM write data
- CPU_HOLD  output  1  stall/reset request to the CPU while loading
- DONE  output  1  one-cycle pulse: frame loaded and checksum good
- ERR  output  1  sticky error flag

Behaviour:
- Reset is asynchronous, active-high: CLK single clock; RST clears all state asynchronously.
- Reset values: DIN_READY=1, WE=0, WA=0, WD=0, CPU_HOLD=0, DONE=0, ERR=0, state=IDLE.
- Frame format: HDR_BYTE, N (1..64), then N word pairs {HI, LO}, then CSUM.
  - Word = {HI[1:0], LO[7:0]}; HI[7:2] ignored.
  - CSUM = (N + all HI + all LO bytes) mod 256.
- States: IDLE -> COUNT -> HI -> LO -> (HI | CSUM) -> IDLE; optional CLEAR state (see Optional Feature).
- IDLE:
  - Accepted bytes other than HDR_BYTE are dropped silently.
  - On HDR_BYTE: ERR<=0, CPU_HOLD<=1, go to COUNT.
- COUNT:
  - N==0 or N>DEPTH: ERR<=1, go to IDLE; CPU_HOLD stays 1.
  - Otherwise latch N, addr<=0, sum<=N, go to HI.
- HI: latch byte, add it to sum, go to LO.
- LO:
  - Add byte to sum.
  - Next cycle: WE=1, WA=addr, WD={HI[1:0],LO} for exactly one cycle; addr increments after the write.
  - After the Nth LO go to CSUM, otherwise to HI.
- CSUM:
  - Match: next cycle DONE=1 for one cycle, CPU_HOLD<=0, go to IDLE.
  - Mismatch: ERR<=1, CPU_HOLD stays 1, go to IDLE.
- Failed frames: any error leaves CPU_HOLD=1 until a later frame completes successfully. Words already written by a failed frame are not rolled back.
- ERR is cleared only by reset or by acceptance of the next HDR_BYTE.
- DIN_READY=1 in every state except CLEAR; stalls (DIN_VALID=0) of any length are allowed in any state without effect.
- HDR_BYTE received mid-frame is treated as ordinary data (no resync).
- Address never wraps: N<=64 guarantees the last write is at WA=N-1<=63.
- Sum is 8-bit, carry discarded.
- Reset mid-frame: state returns to IDLE; CPU_HOLD=0 and any WE pulse in flight is suppressed.

Optional Feature:
- Macro: IMEM_LOADER_CLEAR_EN.
- Defined: after a good CSUM, enter CLEAR (DIN_READY=0).
  - Write WD=10'd0 (NOP) to addresses N..63, one per cycle.
  - Then DONE pulse and CPU_HOLD<=0.
  - N==64 skips CLEAR.
  - Total cycles from CSUM accept to DONE = 64-N+1.
- Not defined: no CLEAR state; unwritten words keep prior contents; DONE one cycle after CSUM accept.

Test Plan:
- Load frame A5,02, 02,3C, 01,81, CSUM=C2 -> WE pulses with (WA=0,WD=0x23C) then (WA=1,WD=0x181); DONE pulse; CPU_HOLD 1->0; ERR=0.
- Same frame with CSUM=C3 -> both writes occur, no DONE, ERR=1, CPU_HOLD stays 1; a following good frame clears ERR on its header and drops CPU_HOLD on DONE.
- Count byte 00, then separately count byte 41 (65) -> ERR=1 immediately, no WE, return to IDLE; junk bytes 11,22 in IDLE produce no writes.
- Full frame N=64 (40) with DIN_VALID toggled randomly -> 64 writes at WA 0..63 in order, no wrap, DONE once.
- Assert RST mid-frame after 3 bytes -> all outputs at reset values; next frame A5,01,00,FF,CSUM=00 writes WA=0,WD=0x0FF.
- With IMEM_LOADER_CLEAR_EN, N=2 frame -> 2 data writes, then 62 zero writes at WA 2..63 with DIN_READY=0, then DONE.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader-side bus: byte stream in, instruction RAM write port and CPU status out.
// Stream handshake: a byte transfers on a rising CLK edge where DIN_VALID and DIN_READY are both 1.
interface imem_loader_if;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic       WE;
    logic [5:0] WA;
    logic [9:0] WD;
    logic       CPU_HOLD;
    logic       DONE;
    logic       ERR;
    logic [2:0] state_dbg;

    modport master (
        input  DIN, DIN_VALID,
        output DIN_READY, WE, WA, WD, CPU_HOLD, DONE, ERR, state_dbg
    );

    modport slave (
        output DIN, DIN_VALID,
        input  DIN_READY, WE, WA, WD, CPU_HOLD, DONE, ERR, state_dbg
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 64x10 instruction RAM.
// Optional macro IMEM_LOADER_CLEAR_EN: after a good frame, fill the unwritten words with NOPs.
module imem_loader #(
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         DEPTH    = 64
) (
    input  logic          CLK,
    input  logic          RST,
    imem_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CSUM  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t     state, nxt_state;
    logic [6:0] cnt, nxt_cnt;
    logic [6:0] addr, nxt_addr;
    logic [7:0] sum, nxt_sum;
    logic [1:0] hi, nxt_hi;
    logic       we, nxt_we;
    logic [5:0] wa, nxt_wa;
    logic [9:0] wd, nxt_wd;
    logic       hold, nxt_hold;
    logic       done, nxt_done;
    logic       err, nxt_err;
    logic       accept;

    assign bus.DIN_READY = (state != S_CLEAR);
    assign accept        = bus.DIN_VALID & bus.DIN_READY;
    assign bus.WE        = we;
    assign bus.WA        = wa;
    assign bus.WD        = wd;
    assign bus.CPU_HOLD  = hold;
    assign bus.DONE      = done;
    assign bus.ERR       = err;
    assign bus.state_dbg = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            sum   <= '0;
            hi    <= '0;
            we    <= 1'b0;
            wa    <= '0;
            wd    <= '0;
            hold  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            addr  <= nxt_addr;
            sum   <= nxt_sum;
            hi    <= nxt_hi;
            we    <= nxt_we;
            wa    <= nxt_wa;
            wd    <= nxt_wd;
            hold  <= nxt_hold;
            done  <= nxt_done;
            err   <= nxt_err;
        end
    end

    // WE and DONE are single-cycle pulses; everything else holds unless updated.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_addr  = addr;
        nxt_sum   = sum;
        nxt_hi    = hi;
        nxt_we    = 1'b0;
        nxt_wa    = wa;
        nxt_wd    = wd;
        nxt_hold  = hold;
        nxt_done  = 1'b0;
        nxt_err   = err;
        case (state)
            S_IDLE: begin
                if (accept && bus.DIN == HDR_BYTE) begin
                    nxt_err   = 1'b0;
                    nxt_hold  = 1'b1;
                    nxt_state = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (bus.DIN == 8'd0 || bus.DIN > DEPTH_B) begin
                        nxt_err   = 1'b1;
                        nxt_state = S_IDLE;
                    end else begin
                        nxt_cnt   = bus.DIN[6:0];
                        nxt_addr  = '0;
                        nxt_sum   = bus.DIN;
                        nxt_state = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    nxt_hi    = bus.DIN[1:0];
                    nxt_sum   = sum + bus.DIN;
                    nxt_state = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    nxt_sum   = sum + bus.DIN;
                    nxt_we    = 1'b1;
                    nxt_wa    = addr[5:0];
                    nxt_wd    = {hi, bus.DIN};
                    nxt_addr  = addr + 7'd1;
                    nxt_state = (addr + 7'd1 == cnt) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.DIN == sum) begin
`ifdef IMEM_LOADER_CLEAR_EN
                        // addr already equals N here, so CLEAR starts at the first unused word.
                        if (cnt == DEPTH_W) begin
                            nxt_done  = 1'b1;
                            nxt_hold  = 1'b0;
                            nxt_state = S_IDLE;
                        end else begin
                            nxt_state = S_CLEAR;
                        end
`else
                        nxt_done  = 1'b1;
                        nxt_hold  = 1'b0;
                        nxt_state = S_IDLE;
`endif
                    end else begin
                        nxt_err   = 1'b1;
                        nxt_state = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                if (addr == DEPTH_W) begin
                    nxt_done  = 1'b1;
                    nxt_hold  = 1'b0;
                    nxt_state = S_IDLE;
                end else begin
                    nxt_we   = 1'b1;
                    nxt_wa   = addr[5:0];
                    nxt_wd   = '0;
                    nxt_addr = addr + 7'd1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end
endmodule
